// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC source sequencer.
// Contents: sequencer state enum, DAC source mux encodings, and the default
// values of the RAMP_STEP / HOLD_CE parameters.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRampDn = 2'd1,
    StHold   = 2'd2,
    StRampUp = 2'd3
  } seq_state_e;

  // DAC source mux select encodings
  localparam logic [1:0] SRC_DOWN = 2'd0;  // downsampled path
  localparam logic [1:0] SRC_UP   = 2'd1;  // upsampled path
  localparam logic [1:0] SRC_ADC  = 2'd2;  // raw ADC
  localparam logic [1:0] SRC_ZERO = 2'd3;  // constant zero

  localparam int unsigned RAMP_STEP_DEF = 4;
  localparam int unsigned HOLD_CE_DEF   = 16;

endpackage

// File: rtl/gain_ramp.sv
// Saturating step-toward-target arithmetic for the gain ramp.
// Ports:
//   cur  - current gain
//   tgt  - ramp target
//   step - maximum change per step
//   en   - perform a step this cycle; otherwise next = cur
//   next - cur moved toward tgt by min(step, |tgt - cur|), never past tgt
module gain_ramp (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  input  logic [7:0] step,
  input  logic       en,
  output logic [7:0] next
);

  logic       up;
  logic [7:0] diff;
  logic [7:0] delta;

  always_comb begin
    up    = tgt > cur;
    diff  = up ? (tgt - cur) : (cur - tgt);
    // Clamping the step to the remaining distance rules out overshoot and wrap
    delta = (step < diff) ? step : diff;
    next  = cur;
    if (en) begin
      next = up ? (cur + delta) : (cur - delta);
    end
  end

endmodule

// File: rtl/dac_src_sequencer.sv
// DAC source/gain sequencer. Changes the DAC source glitch-free by ramping the
// gain to zero, swapping the source mux while muted, holding for HOLD_CE
// upsampler strobes, then ramping up to the requested gain. A request for the
// current source just ramps the gain (either direction) to the new target.
// Ramp and hold timing advance only on ce_up.
//
// Ports:
//   sys_clk   - clock, rising edge
//   rst       - synchronous active-high reset
//   ce_up     - upsampler ce_out strobe
//   req_valid - configuration request present
//   req_ready - request can be accepted (IDLE only)
//   req_src   - requested source (SRC_DOWN/SRC_UP/SRC_ADC/SRC_ZERO)
//   req_gain  - requested target gain
//   gain      - gain applied to the datapath
//   src_sel   - source mux select applied
//   busy      - sequencer not idle
//   done      - one-cycle pulse on request completion
//
// Build option: DAC_SEQ_RAMP_EN. When defined the gain moves by RAMP_STEP per
// strobe; when undefined each ramp jumps straight to its target on its first
// strobe.
module dac_src_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
  parameter int unsigned HOLD_CE   = HOLD_CE_DEF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       ce_up,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [7:0] req_gain,
  output logic [7:0] gain,
  output logic [1:0] src_sel,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] StepCfg  = 8'(RAMP_STEP);
  localparam logic [7:0] HoldLast = 8'(HOLD_CE - 1);

`ifdef DAC_SEQ_RAMP_EN
  localparam logic [7:0] StepVal = StepCfg;
`else
  // A step of 255 always covers the full remaining difference
  localparam logic [7:0] StepVal = StepCfg | 8'hFF;
`endif

  seq_state_e state_q, state_d;
  logic [7:0] gain_q, gain_d;
  logic [1:0] src_sel_q, src_sel_d;
  logic [1:0] src_lat_q, src_lat_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       done_q, done_d;

  logic       ramp_en;
  logic [7:0] ramp_tgt;
  logic [7:0] ramp_next;

  // RAMP_DN always heads for zero; RAMP_UP heads for the latched target
  assign ramp_tgt = (state_q == StRampDn) ? 8'd0 : tgt_q;
  assign ramp_en  = ce_up && ((state_q == StRampDn) || (state_q == StRampUp));

  gain_ramp u_gain_ramp (
    .cur  (gain_q),
    .tgt  (ramp_tgt),
    .step (StepVal),
    .en   (ramp_en),
    .next (ramp_next)
  );

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    src_sel_d  = src_sel_q;
    src_lat_d  = src_lat_q;
    tgt_d      = tgt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          src_lat_d = req_src;
          tgt_d     = req_gain;
          state_d   = (req_src == src_sel_q) ? StRampUp : StRampDn;
        end
      end
      StRampDn: begin
        if (gain_q == 8'd0) begin
          // Swap the source only while muted
          state_d    = StHold;
          src_sel_d  = src_lat_q;
          hold_cnt_d = 8'd0;
        end else begin
          gain_d = ramp_next;
        end
      end
      StHold: begin
        if (ce_up) begin
          if (hold_cnt_q == HoldLast) begin
            state_d = StRampUp;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      StRampUp: begin
        if (gain_q == tgt_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          gain_d = ramp_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gain_q     <= 8'd0;
      src_sel_q  <= SRC_DOWN;
      src_lat_q  <= SRC_DOWN;
      tgt_q      <= 8'd0;
      hold_cnt_q <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      src_sel_q  <= src_sel_d;
      src_lat_q  <= src_lat_d;
      tgt_q      <= tgt_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign gain      = gain_q;
  assign src_sel   = src_sel_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dac_src_sequencer.sv
// Scoreboard bench for dac_src_sequencer. Stimulus pushes the expected
// {src_sel, gain, strobe index} of every output change and the expected final
// state of every done pulse; a monitor pops and compares on each change.
module tb_dac_src_sequencer;

  localparam int RampStep = 4;
  localparam int HoldCe   = 16;
`ifdef DAC_SEQ_RAMP_EN
  localparam int ModelStep = RampStep;
`else
  localparam int ModelStep = 255;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_up = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_src = 2'd0;
  logic [7:0] req_gain = 8'd0;
  logic       req_ready;
  logic [7:0] gain;
  logic [1:0] src_sel;
  logic       busy;
  logic       done;

  dac_src_sequencer #(
    .RAMP_STEP (RampStep),
    .HOLD_CE   (HoldCe)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .ce_up     (ce_up),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_gain  (req_gain),
    .gain      (gain),
    .src_sel   (src_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] src;
    logic [7:0] gain;
    int         idx;   // ce_up strobes since accept; -1 = don't care
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  int         errors = 0;
  int         checks = 0;
  logic [1:0] m_src = 2'd0;
  logic [7:0] m_gain = 8'd0;
  bit         mon_en = 1'b0;
  bit         ce_en = 1'b0;
  int         ce_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic [7:0] step_to(input logic [7:0] g, input logic [7:0] t);
    int d;
    d = (t > g) ? int'(t) - int'(g) : int'(g) - int'(t);
    if (d > ModelStep) d = ModelStep;
    return (t > g) ? g + 8'(d) : g - 8'(d);
  endfunction

  // Expected output changes for one request, starting from the model state
  task automatic push_req(input logic [1:0] src, input logic [7:0] tgt, input bit full);
    int         idx;
    logic [7:0] g;
    idx = 0;
    g   = m_gain;
    if (src != m_src) begin
      while (g != 8'd0) begin
        idx++;
        g = step_to(g, 8'd0);
        gq.push_back('{m_src, g, idx});
      end
      gq.push_back('{src, 8'd0, idx});
      idx += HoldCe;
    end
    m_src  = src;
    m_gain = g;
    if (!full) return;
    while (g != tgt) begin
      idx++;
      g = step_to(g, tgt);
      gq.push_back('{src, g, idx});
    end
    dq.push_back('{src, tgt, -1});
    m_gain = tgt;
  endtask

  // ce_up strobe every 4th cycle while enabled
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge sys_clk);
      if (ce_en) begin
        ph    = (ph + 1) % 4;
        ce_up = (ph == 0);
      end else begin
        ph    = 0;
        ce_up = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      if (req_valid && req_ready) ce_cnt = 0;
      else if (ce_up) ce_cnt++;
    end
  end

  // Monitor
  initial begin
    logic [1:0] p_src;
    logic [7:0] p_gain;
    logic       p_done;
    exp_t       e;
    p_src  = 2'd0;
    p_gain = 8'd0;
    p_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (mon_en) begin
        if ({src_sel, gain} !== {p_src, p_gain}) begin
          if (gq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: got src=%0d gain=%0d expected no change",
                     src_sel, gain);
          end else begin
            e = gq.pop_front();
            chk("chg_src", 32'(src_sel), 32'(e.src));
            chk("chg_gain", 32'(gain), 32'(e.gain));
            if (e.idx >= 0) chk("chg_strobe", ce_cnt, e.idx);
          end
        end
        if (done === 1'b1) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            e = dq.pop_front();
            chk("done_src", 32'(src_sel), 32'(e.src));
            chk("done_gain", 32'(gain), 32'(e.gain));
          end
          chk("done_width", 32'(p_done), 32'd0);
        end
      end
      p_src  = src_sel;
      p_gain = gain;
      p_done = done;
    end
  end

  // Returns just after the accept edge with req_valid still high
  task automatic issue(input logic [1:0] src, input logic [7:0] tgt, input bit full);
    int n;
    @(negedge sys_clk);
    req_src   = src;
    req_gain  = tgt;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 3000) chk("accept_timeout", 32'd1, 32'd0);
    push_req(src, tgt, full);
    @(posedge sys_clk);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got no done expected done within 3000 cycles", name);
  endtask

  task automatic do_reset();
    if ({m_src, m_gain} != 10'd0) gq.push_back('{2'd0, 8'd0, -1});
    m_src  = 2'd0;
    m_gain = 8'd0;
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int viol;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_gain", 32'(gain), 32'd0);
    chk("rst_src", 32'(src_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    mon_en = 1'b1;
    rst    = 1'b0;
    ce_en  = 1'b1;

    // No-overshoot ramp to 10
    issue(2'd0, 8'd10, 1'b1);
    @(negedge sys_clk) req_valid = 1'b0;
    wait_done("done_g10");
    chk("g10_final", 32'(gain), 32'd10);

    // Reset, then ramp 0 -> 128 on the same source
    do_reset();
    issue(2'd0, 8'd128, 1'b1);
    @(negedge sys_clk) req_valid = 1'b0;
    wait_done("done_g128");
    chk("g128_final", 32'(gain), 32'd128);
    chk("g128_src", 32'(src_sel), 32'd0);
    @(negedge sys_clk);
    chk("g128_busy_fell", 32'(busy), 32'd0);

    // Source swap 0 -> 1 with target 64
    issue(2'd1, 8'd64, 1'b1);
    @(negedge sys_clk) req_valid = 1'b0;
    wait_done("done_swap1");
    chk("swap1_gain", 32'(gain), 32'd64);
    chk("swap1_src", 32'(src_sel), 32'd1);

    // req_valid held high through a swap; second request taken on first IDLE cycle
    issue(2'd2, 8'd20, 1'b1);
    @(negedge sys_clk);
    req_gain = 8'd30;
    viol = 0;
    n    = 0;
    while (req_ready !== 1'b1 && n < 3000) begin
      if (busy !== 1'b1) viol++;
      @(negedge sys_clk);
      n++;
    end
    chk("held_ready_low_while_busy", viol, 0);
    chk("held_accept_first_idle", 32'(done), 32'd1);
    push_req(2'd2, 8'd30, 1'b1);
    @(posedge sys_clk);
    @(negedge sys_clk) req_valid = 1'b0;
    wait_done("done_held2");
    chk("held2_gain", 32'(gain), 32'd30);

    // Downward ramp inside RAMP_UP (same source)
    issue(2'd2, 8'd13, 1'b1);
    @(negedge sys_clk) req_valid = 1'b0;
    wait_done("done_down13");
    chk("down13_gain", 32'(gain), 32'd13);

    // Same source, same gain: done two cycles after accept
    ce_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    issue(2'd2, 8'd13, 1'b1);
    @(negedge sys_clk) req_valid = 1'b0;
    chk("same_c1_done", 32'(done), 32'd0);
    chk("same_c1_busy", 32'(busy), 32'd1);
    @(negedge sys_clk);
    chk("same_c2_done", 32'(done), 32'd1);
    chk("same_c2_gain", 32'(gain), 32'd13);
    chk("same_c2_src", 32'(src_sel), 32'd2);
    @(negedge sys_clk);
    chk("same_c3_busy", 32'(busy), 32'd0);
    ce_en = 1'b1;

    // Reset in the middle of HOLD
    issue(2'd3, 8'd77, 1'b0);
    @(negedge sys_clk) req_valid = 1'b0;
    n = 0;
    while (src_sel !== 2'd3 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("hold_reached", 32'(src_sel), 32'd3);
    repeat (6) @(negedge sys_clk);
    gq.push_back('{2'd0, 8'd0, -1});
    m_src  = 2'd0;
    m_gain = 8'd0;
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("hrst_gain", 32'(gain), 32'd0);
    chk("hrst_src", 32'(src_sel), 32'd0);
    chk("hrst_busy", 32'(busy), 32'd0);
    chk("hrst_ready", 32'(req_ready), 32'd1);
    chk("hrst_done", 32'(done), 32'd0);
    repeat (100) @(negedge sys_clk);

    chk("change_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
